// File: rtl/psx_poll_master.sv
`default_nettype none
// ============================================================================
// Module      : psx_poll_master
// Description : Console-side PSX pad poller. Runs one 01,42,00,00,00 poll per
//               start pulse, captures pad ID and buttons, and flags a missing
//               ack or a bad 0x5A marker. Defining PSX_ANALOG_EN adds the
//               9-byte analog-stick poll and the analog output.
// Revision    : 1.0 - initial release
// ============================================================================
module psx_poll_master #(
    parameter int CLK_DIV     = 1,
    parameter int ATT_SETUP   = 4,
    parameter int ACK_TIMEOUT = 25,
    parameter int BYTE_GAP    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        err,
    output logic [7:0]  id,
    output logic [15:0] buttons,
    output logic        att,
    output logic        psx_clk,
    output logic        cmd,
    input  logic        data,
    input  logic        ack
`ifdef PSX_ANALOG_EN
    ,
    output logic [31:0] analog
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    localparam int         c_CNT_W  = 16;
    localparam logic [7:0] c_MARKER = 8'h5A;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_limit;
    logic               w_cnt_done;
    logic               r_phase;       // 0: psx_clk low half, 1: high half
    logic [2:0]         r_bit;
    logic [3:0]         r_idx;
    logic [3:0]         w_last_idx;
    logic [7:0]         r_rx;
    logic [7:0]         w_tx;
    logic               w_byte_end;
    logic               r_err_flag;
    logic [7:0]         r_id_rx;
    logic [15:0]        r_btn_rx;
    logic               r_data_s1;
    logic               r_data_s2;
    logic               r_ack_s1;
    logic               r_ack_s2;

`ifdef PSX_ANALOG_EN
    localparam logic [7:0] c_ANALOG_ID = 8'h73;
    logic        r_ext;
    logic [31:0] r_ana_rx;
    assign w_last_idx = r_ext ? 4'd8 : 4'd4;
`else
    assign w_last_idx = 4'd4;
`endif

    assign w_tx = (r_idx == 4'd0) ? 8'h01 :
                  (r_idx == 4'd1) ? 8'h42 : 8'h00;

    always_comb begin
        w_cnt_limit = '0;
        case (r_state)
            S_SETUP:    w_cnt_limit = c_CNT_W'(ATT_SETUP - 1);
            S_SHIFT:    w_cnt_limit = c_CNT_W'(CLK_DIV - 1);
            S_WAIT_ACK: w_cnt_limit = c_CNT_W'(ACK_TIMEOUT - 1);
            S_GAP:      w_cnt_limit = c_CNT_W'(BYTE_GAP - 1);
            default:    w_cnt_limit = '0;
        endcase
    end

    assign w_cnt_done = (r_cnt == w_cnt_limit);
    assign w_byte_end = (r_state == S_SHIFT) && r_phase && (r_bit == 3'd7) && w_cnt_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_next = S_SETUP;
            S_SETUP:    if (w_cnt_done) w_state_next = S_SHIFT;
            S_SHIFT:    if (w_byte_end)
                            w_state_next = (r_idx < w_last_idx) ? S_WAIT_ACK : S_GAP;
            S_WAIT_ACK: if (!r_ack_s2)       w_state_next = S_GAP;
                        else if (w_cnt_done) w_state_next = S_FINISH;
            S_GAP:      if (w_cnt_done)
                            w_state_next = (r_idx < w_last_idx) ? S_SHIFT : S_FINISH;
            S_FINISH:   w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        att     = 1'b1;
        psx_clk = 1'b1;
        cmd     = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        valid   = 1'b0;
        err     = 1'b0;
        case (r_state)
            S_SETUP, S_WAIT_ACK, S_GAP: begin
                att  = 1'b0;
                busy = 1'b1;
            end
            S_SHIFT: begin
                att     = 1'b0;
                busy    = 1'b1;
                psx_clk = r_phase;
                cmd     = w_tx[r_bit];
            end
            S_FINISH: begin
                done  = 1'b1;
                valid = ~r_err_flag;
                err   = r_err_flag;
            end
            default: ;
        endcase
    end

    // Datapath: synchronisers, timing counter, shifter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
            r_ack_s1   <= 1'b1;
            r_ack_s2   <= 1'b1;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_bit      <= 3'd0;
            r_idx      <= 4'd0;
            r_rx       <= 8'h00;
            r_err_flag <= 1'b0;
            r_id_rx    <= 8'h00;
            r_btn_rx   <= 16'hFFFF;
            id         <= 8'h00;
            buttons    <= 16'hFFFF;
`ifdef PSX_ANALOG_EN
            r_ext      <= 1'b0;
            r_ana_rx   <= 32'h8080_8080;
            analog     <= 32'h8080_8080;
`endif
        end else begin
            r_data_s1 <= data;
            r_data_s2 <= r_data_s1;
            r_ack_s1  <= ack;
            r_ack_s2  <= r_ack_s1;

            // Counter restarts on every state change and on each SHIFT half-period
            if (r_state == S_IDLE || w_state_next != r_state ||
                (r_state == S_SHIFT && w_cnt_done))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CNT_W'(1);

            if (r_state == S_IDLE && start) begin
                r_idx      <= 4'd0;
                r_bit      <= 3'd0;
                r_phase    <= 1'b0;
                r_err_flag <= 1'b0;
`ifdef PSX_ANALOG_EN
                r_ext      <= 1'b0;
`endif
            end

            if (r_state == S_SHIFT && w_cnt_done) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_rx  <= {r_data_s2, r_rx[7:1]};
                else          r_bit <= r_bit + 3'd1;
            end

            if (w_byte_end) begin
                case (r_idx)
                    4'd1: begin
                        r_id_rx <= r_rx;
`ifdef PSX_ANALOG_EN
                        r_ext   <= (r_rx == c_ANALOG_ID);
`endif
                    end
                    4'd2: if (r_rx != c_MARKER) r_err_flag <= 1'b1;
                    4'd3: r_btn_rx[7:0]  <= r_rx;
                    4'd4: r_btn_rx[15:8] <= r_rx;
`ifdef PSX_ANALOG_EN
                    4'd5: r_ana_rx[7:0]   <= r_rx;
                    4'd6: r_ana_rx[15:8]  <= r_rx;
                    4'd7: r_ana_rx[23:16] <= r_rx;
                    4'd8: r_ana_rx[31:24] <= r_rx;
`endif
                    default: ;
                endcase
            end

            if (r_state == S_WAIT_ACK && r_ack_s2 && w_cnt_done)
                r_err_flag <= 1'b1;

            if (r_state == S_GAP && w_cnt_done && r_idx < w_last_idx)
                r_idx <= r_idx + 4'd1;

            // Publish results only on a clean finish so errors keep the last good poll
            if (r_state == S_GAP && w_state_next == S_FINISH && !r_err_flag) begin
                id      <= r_id_rx;
                buttons <= r_btn_rx;
`ifdef PSX_ANALOG_EN
                analog  <= r_ana_rx;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psx_poll_master.sv
`default_nettype none
// Self-checking bench for psx_poll_master: a behavioural pad responder plus a
// transaction-level model of the expected poll outcome.
module tb_psx_poll_master;

    localparam int CLK_DIV     = 1;
    localparam int ATT_SETUP   = 4;
    localparam int ACK_TIMEOUT = 25;
    localparam int BYTE_GAP    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        data;
    logic        ack;
    logic        busy, done, valid, err, att, psx_clk, cmd;
    logic [7:0]  id;
    logic [15:0] buttons;
`ifdef PSX_ANALOG_EN
    logic [31:0] analog;
    logic [31:0] m_analog;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  resp [0:8];
    logic [7:0]  cmd_seen [0:8];
    int          n_bytes  = 5;
    int          ack_skip = -1;
    int          falls    = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          last_rise_cyc = 0;
    int          done_cyc = 0;
    logic [7:0]  m_id;
    logic [15:0] m_btn;

    always #5 clk = ~clk;

    psx_poll_master #(
        .CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP),
        .ACK_TIMEOUT(ACK_TIMEOUT), .BYTE_GAP(BYTE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .valid(valid), .err(err), .id(id), .buttons(buttons), .att(att),
        .psx_clk(psx_clk), .cmd(cmd), .data(data), .ack(ack)
`ifdef PSX_ANALOG_EN
        , .analog(analog)
`endif
    );

    function automatic logic resp_bit(input int idx);
        if (idx < n_bytes * 8) return resp[idx / 8][idx % 8];
        return 1'b1;
    endfunction

    // Pad responder. Each response bit is presented one bit ahead (at the
    // previous psx_clk fall) so it clears the master's 2-flop data synchroniser
    // before the sampling edge when CLK_DIV=1.
    initial begin : responder
        logic prev_psx, prev_att;
        int   ack_wait, ack_hold;
        data = 1'b1; ack = 1'b1; prev_psx = 1'b1; prev_att = 1'b1;
        ack_wait = -1; ack_hold = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (att !== 1'b0) begin
                data = 1'b1; ack = 1'b1; ack_wait = -1; ack_hold = 0;
            end else begin
                if (prev_att) begin
                    falls = 0;
                    for (int b = 0; b < 9; b++) cmd_seen[b] = 8'h00;
                    data = resp_bit(0);
                end
                if (prev_psx && !psx_clk) begin
                    falls++;
                    data = resp_bit(falls);
                    ack = 1'b1; ack_hold = 0;
                end else if (!prev_psx && psx_clk) begin
                    last_rise_cyc = cyc;
                    if (falls >= 1 && falls <= 72) cmd_seen[(falls - 1) / 8][(falls - 1) % 8] = cmd;
                    if (falls % 8 == 0 && (falls / 8 - 1) < n_bytes - 1 && (falls / 8 - 1) != ack_skip)
                        ack_wait = $urandom_range(1, 8);
                end else if (ack_wait > 0) begin
                    ack_wait--;
                    if (ack_wait == 0) begin
                        ack = 1'b0;
                        ack_wait = -1;
                        // sometimes hold ack low until the next byte starts
                        ack_hold = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(1, 4);
                    end
                end else if (ack_hold > 0) begin
                    ack_hold--;
                    if (ack_hold == 0) ack = 1'b1;
                end
            end
            prev_psx = psx_clk;
            prev_att = att;
        end
    end

    task automatic set_resp(input logic [7:0] b0, b1, b2, b3, b4);
        resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3; resp[4] = b4;
        for (int i = 5; i < 9; i++) resp[i] = 8'($urandom_range(0, 255));
    endtask

    // One poll: model the outcome from the response table, run it, compare.
    task automatic do_poll(input string name, input int skip, input bit extra);
        int   exp_nb, exp_falls, dc0;
        bit   exp_err, got, v_s, e_s, a_s, p_s;
        logic [7:0] exp_cmd;
        exp_nb = 5;
`ifdef PSX_ANALOG_EN
        if (resp[1] == 8'h73) exp_nb = 9;
`endif
        n_bytes = exp_nb;
        ack_skip = skip;
        if (skip >= 0 && skip < exp_nb - 1) begin
            exp_err = 1'b1; exp_falls = 8 * (skip + 1);
        end else begin
            exp_err = (resp[2] != 8'h5A); exp_falls = 8 * exp_nb;
        end
        if (!exp_err) begin
            m_id  = resp[1];
            m_btn = {resp[4], resp[3]};
`ifdef PSX_ANALOG_EN
            if (exp_nb == 9) m_analog = {resp[8], resp[7], resp[6], resp[5]};
`endif
        end
        dc0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
        got = 0; v_s = 0; e_s = 0; a_s = 0; p_s = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                got = 1; v_s = valid; e_s = err; a_s = att; p_s = psx_clk;
                if (extra) start = 1'b1;
            end else if (extra && i == 5) begin
                start = 1'b1;
            end
        end
        @(negedge clk); start = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL %s done_timeout: got none want done within 2000 cycles", name); end
        total++;
        if (v_s !== !exp_err) begin bad++; $display("FAIL %s valid: got %b want %b", name, v_s, !exp_err); end
        total++;
        if (e_s !== exp_err) begin bad++; $display("FAIL %s err: got %b want %b", name, e_s, exp_err); end
        total++;
        if (a_s !== 1'b1 || p_s !== 1'b1) begin bad++; $display("FAIL %s att_psxclk_at_done: got %b%b want 11", name, a_s, p_s); end
        total++;
        if (id !== m_id) begin bad++; $display("FAIL %s id: got %h want %h", name, id, m_id); end
        total++;
        if (buttons !== m_btn) begin bad++; $display("FAIL %s buttons: got %h want %h", name, buttons, m_btn); end
`ifdef PSX_ANALOG_EN
        total++;
        if (analog !== m_analog) begin bad++; $display("FAIL %s analog: got %h want %h", name, analog, m_analog); end
`endif
        total++;
        if (falls != exp_falls) begin bad++; $display("FAIL %s psx_clk_falls: got %0d want %0d", name, falls, exp_falls); end
        for (int b = 0; b < exp_falls / 8; b++) begin
            exp_cmd = (b == 0) ? 8'h01 : (b == 1) ? 8'h42 : 8'h00;
            total++;
            if (cmd_seen[b] !== exp_cmd) begin bad++; $display("FAIL %s cmd_byte%0d: got %h want %h", name, b, cmd_seen[b], exp_cmd); end
        end
        if (exp_err && skip >= 0 && skip < exp_nb - 1) begin
            total++;
            if (done_cyc - last_rise_cyc != ACK_TIMEOUT + CLK_DIV) begin
                bad++;
                $display("FAIL %s ack_timeout_cycles: got %0d want %0d", name, done_cyc - last_rise_cyc, ACK_TIMEOUT + CLK_DIV);
            end
        end
        repeat (40) @(negedge clk);
        total++;
        if (done_cnt != dc0 + 1) begin bad++; $display("FAIL %s done_count: got %0d want %0d", name, done_cnt - dc0, 1); end
        total++;
        if (busy !== 1'b0 || att !== 1'b1) begin bad++; $display("FAIL %s idle_after: got busy=%b att=%b want busy=0 att=1", name, busy, att); end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_id = 8'h00; m_btn = 16'hFFFF;
        total++;
        if ({att, psx_clk, cmd} !== 3'b111) begin bad++; $display("FAIL reset_lines: got %b want 111", {att, psx_clk, cmd}); end
        total++;
        if ({busy, done, valid, err} !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b want 0000", {busy, done, valid, err}); end
        total++;
        if (id !== 8'h00) begin bad++; $display("FAIL reset_id: got %h want 00", id); end
        total++;
        if (buttons !== 16'hFFFF) begin bad++; $display("FAIL reset_buttons: got %h want ffff", buttons); end
`ifdef PSX_ANALOG_EN
        m_analog = 32'h8080_8080;
        total++;
        if (analog !== 32'h8080_8080) begin bad++; $display("FAIL reset_analog: got %h want 80808080", analog); end
`endif
    endtask

    task automatic test_nominal;
        set_resp(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F);
        do_poll("nominal", -1, 1'b0);
    endtask

    task automatic test_missing_ack;
        set_resp(8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00);
        do_poll("missing_ack", 1, 1'b0);
    endtask

    task automatic test_bad_marker;
        set_resp(8'hFF, 8'h41, 8'h5B, 8'h12, 8'h34);
        do_poll("bad_marker", -1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int dc0;
        set_resp(8'hFF, 8'h41, 8'h5A, 8'hAA, 8'h55);
        n_bytes = 5; ack_skip = -1;
        dc0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 500 && falls < 17; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_id = 8'h00; m_btn = 16'hFFFF;
`ifdef PSX_ANALOG_EN
        m_analog = 32'h8080_8080;
`endif
        total++;
        if ({att, psx_clk, cmd, busy, done} !== 5'b11100) begin
            bad++; $display("FAIL reset_mid_lines: got %b want 11100", {att, psx_clk, cmd, busy, done});
        end
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt != dc0) begin bad++; $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt - dc0); end
        set_resp(8'hFF, 8'h41, 8'h5A, 8'h3C, 8'hC3);
        do_poll("after_reset", -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        set_resp(8'hFF, 8'h41, 8'h5A, 8'hEF, 8'hBE);
        do_poll("back_to_back", -1, 1'b1);
    endtask

    task automatic test_random;
        int skip;
        for (int n = 0; n < 8; n++) begin
            set_resp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h5A,
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            skip = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            do_poll("random", skip, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef PSX_ANALOG_EN
    task automatic test_analog;
        set_resp(8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF);
        resp[5] = 8'h10; resp[6] = 8'h20; resp[7] = 8'h30; resp[8] = 8'h40;
        do_poll("analog", -1, 1'b1);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 9; i++) resp[i] = 8'hFF;
        test_reset;
        test_nominal;
        test_missing_ack;
        test_bad_marker;
        test_reset_mid;
        test_back_to_back;
        test_random;
`ifdef PSX_ANALOG_EN
        test_analog;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psx_poll_master.md
Name: psx_poll_master

Overview:
- Console-side initiator for the PSX controller port; the host that drives att/psx_clk/cmd and reads data/ack from a controller such as fake_controller.
- On each start pulse it runs one digital poll transaction (0x01,0x42,0x00,0x00,0x00), shifting LSB-first.
- Captures controller ID and button halfword; flags missing ack or bad 0x5A marker.
- Used as bench driver/checker for fake_controller and as real pad reader on hardware.

Parameters:
- CLK_DIV, 1, clk cycles per psx_clk half-period (psx_clk = clk/(2*CLK_DIV)).
- ATT_SETUP, 4, clk cycles from att falling to first psx_clk falling edge.
- ACK_TIMEOUT, 25, max clk cycles to wait for ack low after bytes 0..3.
- BYTE_GAP, 2, clk cycles after ack seen (or after byte 4) before next byte or att release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to poll; ignored while busy
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at transaction end (success or error)
- valid  out  1  one-cycle pulse with done when transaction succeeded
- err  out  1  one-cycle pulse with done on ack timeout or marker mismatch
- id  out  8  response byte 1 of last successful poll (0x41 = digital pad)
- buttons  out  16  {byte4,byte3} of last successful poll, active-low
- att  out  1  attention, active-low
- psx_clk  out  1  serial clock, idles high
- cmd  out  1  command bit, idles high
- data  in  1  controller response bit (open-drain, pulled high externally)
- ack  in  1  controller acknowledge, active-low pulse

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: att=1, psx_clk=1, cmd=1, busy=0, done=0, valid=0, err=0, id=0x00, buttons=0xFFFF, FSM=IDLE.
- rst asserted mid-transaction: on that edge att/psx_clk/cmd return high, no done/valid/err pulse.
- ack and data pass through 2-flop synchronisers before use.
- FSM states:
  - IDLE: start=1 -> att=0, busy=1, byte index=0, SETUP.
  - SETUP: wait ATT_SETUP cycles -> SHIFT.
  - SHIFT: per bit i=0..7: psx_clk=0 and cmd=tx[i] for CLK_DIV cycles; then psx_clk=1 for CLK_DIV cycles. Sample synced data into rx[i] on the edge that drives psx_clk 0->1. After bit 7 high phase: index<4 -> WAIT_ACK; index=4 -> GAP.
  - WAIT_ACK: ack low within ACK_TIMEOUT cycles -> GAP. Otherwise -> FINISH with error.
  - GAP: wait BYTE_GAP cycles; index<4 -> index+1, SHIFT; index=4 -> FINISH.
  - FINISH: att=1, cmd=1, psx_clk=1, busy=0, done=1, plus valid or err; -> IDLE.
- tx bytes: 0x01, 0x42, 0x00, 0x00, 0x00.
- rx byte 0 is ignored.
- rx byte 2 must be 0x5A; a mismatch sets an error flag, reported at FINISH. The transaction still completes all 5 bytes.
- id and buttons update only on success (valid cycle); on error they retain previous values.
- start coincident with done is ignored; start while busy is ignored.
- ack held low continuously is accepted once per byte; no further edge is required.

Optional Feature:
- PSX_ANALOG_EN defined:
  - Adds output analog[31:0] = {LY,LX,RY,RX}, reset 0x80808080.
  - When rx byte1 = 0x73, extends to 9 bytes (four more 0x00 tx).
  - Waits for ack after byte 4 and stops ack-wait after byte 8.
  - analog updates on success.
- Undefined: always 5 bytes, no analog port, behaviour exactly as above.

Test Plan:
- Reset: rst=1 for 3 cycles -> att=1, psx_clk=1, cmd=1, buttons=0xFFFF, id=0x00, busy=0.
- Nominal poll: responder returns FF,41,5A,FE,7F with ack after bytes 0-3 -> cmd stream LSB-first 01,42,00,00,00; 40 psx_clk falls; done+valid; id=0x41, buttons=0x7FFE; err=0.
- Missing ack after byte 1 -> done+err after ACK_TIMEOUT=25 cycles; att high; id/buttons unchanged; only 16 psx_clk falls.
- Bad marker: byte2 = 0x5B -> all 5 bytes run, done+err, buttons unchanged.
- rst asserted during byte 2 -> next edge att=1, psx_clk=1, busy=0, no done. A following start runs a clean poll returning valid.
- start pulsed while busy, and again on done cycle -> exactly one transaction; with PSX_ANALOG_EN and id=0x73 -> 72 psx_clk falls, analog set from bytes 5-8.
